// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone single-transfer initiator: state encoding,
// bus widths and the user-area register map it normally talks to.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [ADR_W-1:0] REG_A_ADDR = 32'h3003_0004;
    localparam logic [ADR_W-1:0] REG_B_ADDR = 32'h3003_0008;
    localparam logic [ADR_W-1:0] REG_C_ADDR = 32'h3003_000C;

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: one read or write at a time from a command port.
// Optional ack timeout abort is enabled by defining WB_TIMEOUT_EN.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_addr,
    input  logic [DAT_W-1:0] cmd_wdata,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             rsp_valid,
    output logic [DAT_W-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [ADR_W-1:0] wbm_adr_o,
    output logic [DAT_W-1:0] wbm_dat_o,
    output logic [SEL_W-1:0] wbm_sel_o,
    input  logic [DAT_W-1:0] wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic [CNT_W-1:0] txn_count
);

    state_t state, state_next;
    logic   timeout_hit;

`ifdef WB_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Abort on the last waiting cycle unless ack arrives on that same edge.
    assign timeout_hit = (state == BUS) && !wbm_ack_i &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state != BUS) begin
            wait_cnt <= '0;
        end else if (!wbm_ack_i) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = BUS;
            BUS:     if (wbm_ack_i || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_addr;
                        wbm_dat_o <= cmd_wdata;
                        wbm_sel_o <= cmd_sel;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wbm_we_o ? '0 : wbm_dat_i;
                        txn_count <= txn_count + CNT_W'(1);
                    end else if (timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator with a small register-file responder.
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic [15:0] txn_count;

    logic        d2_cmd_ready;
    logic        d2_rsp_valid;
    logic [31:0] d2_rsp_rdata;
    logic        d2_rsp_err;
    logic        d2_cyc;
    logic        d2_stb;
    logic        d2_we;
    logic [31:0] d2_adr;
    logic [31:0] d2_dat;
    logic [3:0]  d2_sel;
    logic [1:0]  d2_txn_count;

    wb_initiator #(.TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .txn_count(txn_count)
    );

    // Narrow-counter copy sees identical inputs, so it tracks u_dut modulo 4.
    wb_initiator #(.TIMEOUT_CYCLES(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(d2_rsp_valid), .rsp_rdata(d2_rsp_rdata), .rsp_err(d2_rsp_err),
        .wbm_cyc_o(d2_cyc), .wbm_stb_o(d2_stb), .wbm_we_o(d2_we),
        .wbm_adr_o(d2_adr), .wbm_dat_o(d2_dat), .wbm_sel_o(d2_sel),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .txn_count(d2_txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: acks ack_dly+1 cycles after it first sees stb.
    logic        resp_en;
    logic        spur_ack;
    int unsigned ack_dly;
    int unsigned wcnt;
    logic        ack_r;
    logic [31:0] mem [3];

    assign wbm_ack_i = ack_r | spur_ack;

    function automatic int map_idx(input logic [31:0] a);
        if (a == REG_A_ADDR) return 0;
        if (a == REG_B_ADDR) return 1;
        if (a == REG_C_ADDR) return 2;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r     <= 1'b0;
            wcnt      <= 0;
            wbm_dat_i <= '0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
        end else begin
            ack_r <= 1'b0;
            if (resp_en && wbm_cyc_o && wbm_stb_o && !ack_r) begin
                if (wcnt == ack_dly) begin
                    int idx;
                    idx   = map_idx(wbm_adr_o);
                    ack_r <= 1'b1;
                    wcnt  <= 0;
                    wbm_dat_i <= (idx < 0) ? 32'h0 : mem[idx];
                    if (wbm_we_o && idx >= 0) begin
                        for (int b = 0; b < 4; b++)
                            if (wbm_sel_o[b]) mem[idx][b*8 +: 8] <= wbm_dat_o[b*8 +: 8];
                    end
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else begin
                wcnt <= 0;
            end
        end
    end

    int unsigned rsp_pulses;
    int unsigned overlap;
    initial begin
        rsp_pulses = 0;
        overlap    = 0;
    end
    always @(negedge clk) begin
        if (rsp_valid) rsp_pulses++;
        if (cmd_ready && (wbm_cyc_o || rsp_valid)) overlap++;
    end

    int unsigned n_checks;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int unsigned t_cyc;
    logic        t_stable;
    logic        t_we;
    logic [3:0]  t_sel;
    logic        t_tmo;
    logic        t_ready_at_rsp;

    // Issue one command from a negedge; returns at the negedge where rsp_valid is high.
    task automatic do_cmd(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel);
        int unsigned n;
        logic        first;
        logic [31:0] s_adr, s_dat;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        t_cyc = 0;
        t_stable = 1'b1;
        first = 1'b1;
        s_adr = '0;
        s_dat = '0;
        while (!rsp_valid && n < 200) begin
            if (wbm_cyc_o) begin
                t_cyc++;
                if (first) begin
                    first = 1'b0;
                    s_adr = wbm_adr_o;
                    s_dat = wbm_dat_o;
                    t_we  = wbm_we_o;
                    t_sel = wbm_sel_o;
                end else if (wbm_adr_o !== s_adr || wbm_dat_o !== s_dat ||
                             wbm_we_o !== t_we || wbm_sel_o !== t_sel) begin
                    t_stable = 1'b0;
                end
                if (!wbm_stb_o) t_stable = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        t_tmo = !rsp_valid;
        t_ready_at_rsp = cmd_ready;
    endtask

    initial begin
        int unsigned n;
        int unsigned base;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_sel   = '0;
        resp_en   = 1'b1;
        spur_ack  = 1'b0;
        ack_dly   = 0;
        repeat (2) @(negedge clk);

        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_cyc", 32'(wbm_cyc_o), 32'd0);
        check("reset_stb", 32'(wbm_stb_o), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_txn_count", 32'(txn_count), 32'd0);
        check("reset_adr", wbm_adr_o, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write REG_A
        do_cmd(1'b1, REG_A_ADDR, 32'h000A_BCDE, 4'hF);
        check("t1_no_timeout", 32'(t_tmo), 32'd0);
        check("t1_cyc_cycles", t_cyc, 32'd2);
        check("t1_bus_stable", 32'(t_stable), 32'd1);
        check("t1_we", 32'(t_we), 32'd1);
        check("t1_rsp_err", 32'(rsp_err), 32'd0);
        check("t1_rsp_rdata", rsp_rdata, 32'd0);
        check("t1_txn_count", 32'(txn_count), 32'd1);
        check("t1_ready_in_resp", 32'(t_ready_at_rsp), 32'd0);
        check("t1_cyc_in_resp", 32'(wbm_cyc_o), 32'd0);
        @(negedge clk);
        check("t1_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("t1_ready_after", 32'(cmd_ready), 32'd1);
        check("t1_we_idle", 32'(wbm_we_o), 32'd0);
        check("t1_dat_hold", wbm_dat_o, 32'h000A_BCDE);

        // 2: read back and unmapped read
        do_cmd(1'b0, REG_A_ADDR, 32'h0, 4'hF);
        check("t2_rdata", rsp_rdata, 32'h000A_BCDE);
        check("t2_txn_count", 32'(txn_count), 32'd2);
        check("t2_we", 32'(t_we), 32'd0);
        @(negedge clk);
        do_cmd(1'b0, 32'h3003_0010, 32'h0, 4'hF);
        check("t2_unmapped_rdata", rsp_rdata, 32'd0);
        check("t2_txn_count3", 32'(txn_count), 32'd3);
        @(negedge clk);

        // 3: byte-lane write then read
        do_cmd(1'b1, REG_C_ADDR, 32'hFFFF_FF5A, 4'h1);
        check("t3_sel", 32'(t_sel), 32'h1);
        check("t3_wr_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        do_cmd(1'b0, REG_C_ADDR, 32'h0, 4'hF);
        check("t3_rdata", rsp_rdata, 32'h0000_005A);
        check("t3_txn_count", 32'(txn_count), 32'd5);
        @(negedge clk);

`ifdef WB_TIMEOUT_EN
        // 4: no ack -> abort after 8 cycles; ack on the 8th edge -> normal
        resp_en = 1'b0;
        do_cmd(1'b0, REG_A_ADDR, 32'h0, 4'hF);
        check("t4_tmo_cyc_cycles", t_cyc, 32'd8);
        check("t4_tmo_err", 32'(rsp_err), 32'd1);
        check("t4_tmo_rdata", rsp_rdata, 32'd0);
        check("t4_tmo_count", 32'(txn_count), 32'd5);
        resp_en = 1'b1;
        ack_dly = 6;
        @(negedge clk);
        do_cmd(1'b0, REG_A_ADDR, 32'h0, 4'hF);
        check("t4_edge_cyc_cycles", t_cyc, 32'd8);
        check("t4_edge_err", 32'(rsp_err), 32'd0);
        check("t4_edge_rdata", rsp_rdata, 32'h000A_BCDE);
        check("t4_edge_count", 32'(txn_count), 32'd6);
        ack_dly = 0;
        @(negedge clk);
        base = 6;
`else
        base = 5;
`endif

        // 5: three back-to-back commands with cmd_valid held high
        begin
            logic [31:0] c_addr [3];
            logic [31:0] c_data [3];
            logic        c_we   [3];
            int unsigned p0, o0;
            c_addr[0] = REG_B_ADDR; c_data[0] = 32'h1122_3344; c_we[0] = 1'b1;
            c_addr[1] = REG_A_ADDR; c_data[1] = 32'hCAFE_F00D; c_we[1] = 1'b1;
            c_addr[2] = REG_B_ADDR; c_data[2] = 32'h0;         c_we[2] = 1'b0;
            p0 = rsp_pulses;
            o0 = overlap;
            cmd_sel = 4'hF;
            cmd_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cmd_we = c_we[k];
                cmd_addr = c_addr[k];
                cmd_wdata = c_data[k];
                n = 0;
                while (!cmd_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
            end
            cmd_valid = 1'b0;
            n = 0;
            while (rsp_pulses < p0 + 3 && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            check("t5_rsp_pulses", rsp_pulses - p0, 32'd3);
            check("t5_no_overlap", overlap - o0, 32'd0);
            check("t5_rdata", rsp_rdata, 32'h1122_3344);
            check("t5_txn_count", 32'(txn_count), base + 3);
            spur_ack = 1'b1;
            @(negedge clk);
            spur_ack = 1'b0;
            check("t5_spur_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            check("t5_spur_rsp_next", 32'(rsp_valid), 32'd0);
            check("t5_spur_count", 32'(txn_count), base + 3);
            check("t5_spur_ready", 32'(cmd_ready), 32'd1);
        end

        // 6: async reset mid-transfer, then counter wrap on the 2-bit copy
        cmd_we = 1'b1;
        cmd_addr = REG_A_ADDR;
        cmd_wdata = 32'h1234_5678;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t6_cyc_before_rst", 32'(wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t6_rst_stb", 32'(wbm_stb_o), 32'd0);
        check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rst_ready", 32'(cmd_ready), 32'd1);
        check("t6_rst_count", 32'(txn_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", 32'(cmd_ready), 32'd1);
        check("t6_no_rsp_after", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_cmd(1'b1, REG_B_ADDR, 32'(i), 4'hF);
            @(negedge clk);
        end
        check("t6_count16", 32'(txn_count), 32'd5);
        check("t6_count2_wrap", 32'(d2_txn_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Wishbone classic single-transfer bus initiator. It drives the user-area Wishbone responders (e.g. the 0x3003_0004/08/0C register block) from a simple command/response interface. Typical uses are an on-chip sequencer and test stimulus in place of the management core. It issues one read or write at a time, returns read data and completion status, and counts completed transfers.

Parameters:
- TIMEOUT_CYCLES, default 255: maximum number of cycles stb is held waiting for ack before abort. Only used when WB_TIMEOUT_EN is defined. Range 1..65535.
- CNT_W, default 16: width of the completed-transfer counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active low
- cmd_valid  in  1  command request
- cmd_ready  out  1  initiator idle and able to accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_sel  in  4  byte lanes
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  timeout abort; qualified by rsp_valid
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_sel_o  out  4  Wishbone byte select
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge
- txn_count  out  CNT_W  completed transfers, wraps modulo 2^CNT_W; errors are not counted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active low.
- Reset values: all outputs 0 except cmd_ready, which is 1. State is IDLE.
- All outputs are registered except cmd_ready, which is decoded directly from state (cmd_ready = state==IDLE).

FSM states: IDLE, BUS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready at edge N, latch we/addr/wdata/sel into the wbm_* registers and set cyc=stb=1.
  - From cycle N+1 the bus is driven and state is BUS.
- BUS:
  - cyc, stb, adr, dat_o, sel and we are held stable until ack.
  - On wbm_ack_i at edge M:
    - cyc=stb=0 in cycle M+1.
    - rsp_rdata = wbm_dat_i for a read, 0 for a write.
    - rsp_valid=1 and rsp_err=0.
    - txn_count += 1.
    - State goes to RESP.
- RESP: lasts one cycle (rsp_valid high). rsp_valid is then cleared and state returns to IDLE.
- Minimum command-to-command spacing with a one-cycle-ack responder is 4 cycles.
- rsp_rdata and rsp_err hold their value until the next completion.
- There is no response back-pressure; the consumer must sample on rsp_valid.
- wbm_ack_i while in IDLE or RESP is ignored: no counter change, no response.
- cmd_valid while not ready is ignored and has no side effect. The requester holds the command until it sees cmd_ready.
- Reset asserted mid-transfer immediately drops cyc/stb. No response is generated.
- txn_count wraps from 2^CNT_W-1 to 0.
- wbm_we_o is 0 and wbm_dat_o holds its last value whenever cyc=0.

Optional Feature:
Macro WB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUS and increments each BUS cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack, cyc/stb drop and the transfer completes with rsp_valid=1, rsp_err=1, rsp_rdata=0. txn_count is unchanged.
  - An ack on the same edge the count is reached wins, and the transfer completes normally.
- Not defined: there is no counter, BUS waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2-bit enum: IDLE, BUS, RESP);
  - the register address constants 0x30030004, 0x30030008 and 0x3003000C;
  - the Wishbone width constants (ADR_W=32, DAT_W=32, SEL_W=4).
- Single module; no sub-module. The timeout counter is inline, guarded by the macro.

Test Plan:
1. Write cmd addr=0x30030004, wdata=0x000ABCDE, sel=0xF, with a responder acking one cycle after stb -> cyc/stb high for 2 cycles, adr/dat stable, rsp_valid one cycle with rsp_err=0 and rsp_rdata=0, txn_count=1.
2. Read of 0x30030004 after test 1 -> rsp_rdata=0x000ABCDE, txn_count=2. Then read 0x30030010 (unmapped; responder acks with 0) -> rsp_rdata=0.
3. Byte-lane write sel=0x1, wdata=0xFFFFFF5A to 0x3003000C, then read back -> wbm_sel_o=0x1 during the write; rsp_rdata=0x0000005A.
4. With WB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, the responder never acks -> cyc drops after 8 BUS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, txn_count unchanged. Ack coinciding with the 8th cycle -> normal completion.
5. cmd_valid held high continuously with 3 queued commands -> exactly 3 transfers with no overlap, cmd_ready low from acceptance to end of RESP, and a spurious ack in IDLE is ignored.
6. rst_n pulsed low while in BUS -> cyc/stb/rsp_valid go to 0 asynchronously and cmd_ready=1 after release. Set CNT_W=2 and run 5 transfers -> txn_count=1.
